// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data-memory arbiter: one access channel
// (request fields, same-cycle grant, 1-cycle-later load return).
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    // The requester drives the access and watches grant/return data.
    modport master (
        output req, we, funct3, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter sees the access and answers with grant/return data.
    modport slave (
        input  req, we, funct3, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single data-memory/MMIO port.
// Requester 0 is the CPU load/store unit, requester 1 a DMA/debug master.
// One access per cycle is granted combinationally and forwarded unchanged;
// load data (1-cycle latency) is routed back to whichever requester issued it.
module dmem_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          dmem_wren,
    output logic [2:0]    dmem_funct3,
    output logic [31:0]   dmem_address,
    output logic [31:0]   dmem_data_in,
    input  logic [31:0]   dmem_data_out
);

    localparam logic [3:0] MaxWait = 4'(CPU_MAX_WAIT);

    typedef enum logic {
        OwnerM0 = 1'b0,
        OwnerM1 = 1'b1
    } owner_t;

    owner_t      r_rrLast;
    owner_t      r_rdOwner;
    logic        r_rdPend;
    logic [3:0]  r_waitCnt;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_cpuStarved;
    logic        w_rvalid0;
    logic        w_rvalid1;

    // Pick the winner this cycle: a lone requester always wins; on contention a
    // CPU that has waited the maximum wins, otherwise whoever lost last time.
    always_comb begin
        w_cpuStarved = (r_waitCnt == MaxWait);
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (!reset) begin
            if (m0.req && !m1.req) begin
                w_gnt0 = 1'b1;
            end else if (!m0.req && m1.req) begin
                w_gnt1 = 1'b1;
            end else if (m0.req && m1.req) begin
                if (w_cpuStarved || (r_rrLast == OwnerM1)) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end
        end
    end

    // Forward the granted access untouched; an idle port presents a harmless word load of 0.
    always_comb begin
        dmem_wren    = 1'b0;
        dmem_funct3  = 3'b010;
        dmem_address = '0;
        dmem_data_in = '0;
        if (w_gnt0) begin
            dmem_wren    = m0.we;
            dmem_funct3  = m0.funct3;
            dmem_address = m0.addr;
            dmem_data_in = m0.wdata;
        end else if (w_gnt1) begin
            dmem_wren    = m1.we;
            dmem_funct3  = m1.funct3;
            dmem_address = m1.addr;
            dmem_data_in = m1.wdata;
        end
    end

    // Track round-robin history, the CPU's consecutive lost cycles, and who owns the load in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrLast  <= OwnerM1;
            r_waitCnt <= 4'd0;
            r_rdOwner <= OwnerM0;
            r_rdPend  <= 1'b0;
        end else begin
            if (w_gnt0) begin
                r_rrLast <= OwnerM0;
            end else if (w_gnt1) begin
                r_rrLast <= OwnerM1;
            end

            if (m0.req && !w_gnt0) begin
                if (!w_cpuStarved) begin
                    r_waitCnt <= r_waitCnt + 4'd1;
                end
            end else begin
                r_waitCnt <= 4'd0;
            end

            r_rdPend <= (w_gnt0 && !m0.we) || (w_gnt1 && !m1.we);
            if (w_gnt0) begin
                r_rdOwner <= OwnerM0;
            end else if (w_gnt1) begin
                r_rdOwner <= OwnerM1;
            end
        end
    end

    // Steer the returning load word to its owner; a reset landing on the return cycle swallows it.
    always_comb begin
        w_rvalid0 = r_rdPend && !reset && (r_rdOwner == OwnerM0);
        w_rvalid1 = r_rdPend && !reset && (r_rdOwner == OwnerM1);
    end

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = w_rvalid0;
    assign m1.rvalid = w_rvalid1;
    assign m0.rdata  = w_rvalid0 ? dmem_data_out : 32'd0;
    assign m1.rdata  = w_rvalid1 ? dmem_data_out : 32'd0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single data-memory/MMIO port (data RAM at 0x00000000–0x00000FFF; LEDs, millis and micros at 0xFFFFFFF4–0xFFFFFFFC).
- Requester 0 is the CPU load/store unit. Requester 1 is a secondary master (DMA or debug loader).
- Grants at most one access per cycle, forwards it unchanged to the memory port, and routes the 1-cycle-latency read data back to the requester that issued it.
- Round-robin arbitration with a bounded-wait guarantee for the CPU.

Parameters:
- CPU_MAX_WAIT, 4: maximum consecutive cycles requester 0 may be held off while requesting. At the limit it wins the next arbitration unconditionally. Range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  1=store, 0=load
- m0_funct3  in  3  RISC-V load/store funct3 (size/sign)
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data, low-aligned as for the memory port
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  load data valid
- m0_rdata  out  32  load data
- m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for requester 1
- dmem_wren  out  1  to memory port write enable
- dmem_funct3  out  3  to memory port funct3
- dmem_address  out  32  to memory port address
- dmem_data_in  out  32  to memory port write data
- dmem_data_out  in  32  from memory port; valid the cycle after the access is presented

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Values during and after reset:
  - m0_rvalid=0, m1_rvalid=0, rr_last=1 (requester 0 favoured first), wait_cnt=0, rd_owner cleared.
  - m*_gnt are combinational and forced to 0 while reset=1.
  - dmem_wren=0 while reset=1.
- Arbitration is combinational, in the same cycle as req:
  - Only one requester active: grant it.
  - Both requesting and wait_cnt==CPU_MAX_WAIT: grant requester 0.
  - Otherwise, both requesting: grant the requester that was not granted last (rr_last).
  - At most one gnt is high per cycle.
- Memory port drive:
  - When gnt_k=1: dmem_address=mk_addr, dmem_funct3=mk_funct3, dmem_data_in=mk_wdata, dmem_wren=mk_we.
  - No grant: dmem_wren=0, dmem_address=0, dmem_funct3=3'b010, dmem_data_in=0.
- Handshake:
  - A requester holds req and all its fields stable until it sees gnt=1 in the same cycle.
  - A transfer completes on the req&&gnt cycle.
  - A requester may assert req again in the very next cycle, so back-to-back accesses are allowed, one per cycle.
  - Stores have no response.
- Read return:
  - On a granted load, register rd_owner=k and rd_pend=1.
  - Next cycle: mk_rvalid=1 for exactly one cycle and mk_rdata=dmem_data_out. The other requester sees rvalid=0.
  - m*_rdata is 0 whenever its rvalid=0.
  - Pipelined loads from alternating requesters each return in order, 1 cycle after their own grant.
- rr_last updates to the granted index on every grant. Unchanged when no grant.
- wait_cnt (4-bit):
  - Increments when m0_req=1 and m0_gnt=0, saturating at CPU_MAX_WAIT.
  - Clears to 0 on m0_gnt or when m0_req=0.
- Boundary conditions:
  - Reset asserted while a load is in flight: the pending rvalid is suppressed and never issued.
  - Reset deasserted: the first cycle with both requesting grants requester 0.
  - Address decoding (RAM vs MMIO) belongs to the memory port. The arbiter passes every address unmodified, including unmapped ones, whose loads return 0.

Test Plan:
- Reset held 2 cycles with both reqs high -> m0_gnt=m1_gnt=0, dmem_wren=0, rvalids 0; first cycle after reset with both reqs high -> m0_gnt=1.
- m0 stores word 0xDEADBEEF to 0x10, then loads lw 0x10 -> m0_gnt each cycle; the load returns m0_rvalid=1 one cycle after its grant, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Both requesting loads continuously (CPU_MAX_WAIT=4) -> grants alternate m0,m1,m0,m1; each rvalid goes to the correct requester one cycle after its own grant.
- CPU_MAX_WAIT=1, m0 and m1 both requesting, forced so m1 wins once -> m0 wins the next arbitration; wait_cnt never exceeds 1.
- m1 sb 0xFF to 0xFFFFFFFE, then m1 lw 0xFFFFFFFC -> m1_rdata=0x00FF0000; red LED PWM duty reaches 255/256.
- m0 load granted, reset asserted the next cycle -> m0_rvalid stays 0; after release, a new load returns correct data.
